// File: rtl/multiplier_arbiter_if.sv
// Bundle between the four requesters, the shared multiplier and the response consumer.
// "slave" is the arbiter side; "master" is the surrounding environment.
interface multiplier_arbiter_if;
    logic [3:0]  io_req_valid;
    logic [3:0]  io_req_ready;
    logic [63:0] io_req_a;
    logic [63:0] io_req_b;
    logic        io_mul_in_valid;
    logic [15:0] io_mul_in_a;
    logic [15:0] io_mul_in_b;
    logic [15:0] io_mul_out_result;
    logic        io_resp_valid;
    logic        io_resp_ready;
    logic [1:0]  io_resp_id;
    logic [15:0] io_resp_data;

    modport slave (
        input  io_req_valid, io_req_a, io_req_b, io_mul_out_result, io_resp_ready,
        output io_req_ready, io_mul_in_valid, io_mul_in_a, io_mul_in_b,
               io_resp_valid, io_resp_id, io_resp_data
    );

    modport master (
        output io_req_valid, io_req_a, io_req_b, io_mul_out_result, io_resp_ready,
        input  io_req_ready, io_mul_in_valid, io_mul_in_a, io_mul_in_b,
               io_resp_valid, io_resp_id, io_resp_data
    );
endinterface

// File: rtl/multiplier_arbiter.sv
// Round-robin front end for a shared fixed-latency FP16 multiplier: grants one of four
// requesters per cycle under a credit limit and returns products in issue order.
module multiplier_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clock,
    input  logic                reset,
    multiplier_arbiter_if.slave bus
);
    localparam int ID_W  = 2;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);

    logic [ID_W-1:0]    rr_ptr_r;
    logic [CNT_W-1:0]   credit_r;
    logic [ID_W-1:0]    cand_s;
    logic               hit_s;
    logic               found_s;
    logic               grant_valid_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [NUM_REQ-1:0] grant_s;

    logic               issue_valid_r;
    logic [ID_W-1:0]    issue_id_r;
    logic [15:0]        issue_a_r;
    logic [15:0]        issue_b_r;

    logic [MUL_LATENCY-1:0] pipe_valid_r;
    logic [ID_W-1:0]        pipe_id_r [MUL_LATENCY];

    logic [15:0]      fifo_data_r [FIFO_DEPTH];
    logic [ID_W-1:0]  fifo_id_r   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] fifo_count_r;
    logic             push_s;
    logic             pop_s;
    logic             resp_valid_s;

    assign push_s       = pipe_valid_r[MUL_LATENCY-1];
    assign resp_valid_s = (fifo_count_r != {CNT_W{1'b0}});
    assign pop_s        = resp_valid_s & bus.io_resp_ready;

    // Round-robin search from the pointer; registered credit means a same-cycle pop never opens a grant.
    always_comb begin
        cand_s        = rr_ptr_r;
        hit_s         = 1'b0;
        found_s       = 1'b0;
        grant_id_s    = rr_ptr_r;
        grant_s       = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s     = rr_ptr_r + ID_W'(k);
            hit_s      = !found_s && bus.io_req_valid[cand_s];
            grant_id_s = hit_s ? cand_s : grant_id_s;
            found_s    = found_s | hit_s;
        end
        grant_valid_s       = found_s & reset & (credit_r < CREDIT_MAX);
        grant_s[grant_id_s] = grant_valid_s;
    end

    assign bus.io_req_ready = grant_s;

    // Arbitration pointer and outstanding-credit counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= {ID_W{1'b0}};
            credit_r <= {CNT_W{1'b0}};
        end else begin
            if (grant_valid_s) begin
                rr_ptr_r <= grant_id_s + 2'd1;
            end
            credit_r <= credit_r + CNT_W'(grant_valid_s) - CNT_W'(pop_s);
        end
    end

    // Issue register: operands hold their last granted value between issues.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_valid_r <= 1'b0;
            issue_id_r    <= {ID_W{1'b0}};
            issue_a_r     <= 16'h0000;
            issue_b_r     <= 16'h0000;
        end else begin
            issue_valid_r <= grant_valid_s;
            if (grant_valid_s) begin
                issue_id_r <= grant_id_s;
                issue_a_r  <= bus.io_req_a[{grant_id_s, 4'b0000} +: 16];
                issue_b_r  <= bus.io_req_b[{grant_id_s, 4'b0000} +: 16];
            end
        end
    end

    assign bus.io_mul_in_valid = issue_valid_r;
    assign bus.io_mul_in_a     = issue_a_r;
    assign bus.io_mul_in_b     = issue_b_r;

    // In-flight tracker aligned with the multiplier latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_valid_r <= {MUL_LATENCY{1'b0}};
            for (int k = 0; k < MUL_LATENCY; k++) begin
                pipe_id_r[k] <= {ID_W{1'b0}};
            end
        end else begin
            pipe_valid_r[0] <= issue_valid_r;
            pipe_id_r[0]    <= issue_id_r;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                pipe_valid_r[k] <= pipe_valid_r[k-1];
                pipe_id_r[k]    <= pipe_id_r[k-1];
            end
        end
    end

    // Result FIFO; credits guarantee a free slot for every push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            fifo_count_r <= {CNT_W{1'b0}};
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fifo_data_r[k] <= 16'h0000;
                fifo_id_r[k]   <= {ID_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= bus.io_mul_out_result;
                fifo_id_r[wr_ptr_r]   <= pipe_id_r[MUL_LATENCY-1];
                wr_ptr_r              <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + 1'b1;
            end
            fifo_count_r <= fifo_count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    assign bus.io_resp_valid = resp_valid_s;
    assign bus.io_resp_id    = fifo_id_r[rd_ptr_r];
    assign bus.io_resp_data  = fifo_data_r[rd_ptr_r];
endmodule

// File: tb/tb_multiplier_arbiter.sv
// Scoreboard bench for multiplier_arbiter: grants push expected responses, a negedge
// monitor pops and compares; a small delay-line model stands in for the multiplier.
module tb_multiplier_arbiter;
    localparam int MUL_LATENCY = 3;
    localparam int FIFO_DEPTH  = 4;

    logic clock;
    logic reset;
    multiplier_arbiter_if bus();

    multiplier_arbiter #(
        .NUM_REQ(4), .MUL_LATENCY(MUL_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    int          checks = 0;
    int          passes = 0;
    int          resp_seen = 0;
    logic [17:0] exp_q [$];
    int          gnt_log [$];
    logic [15:0] mstage [MUL_LATENCY];
    logic        mv;
    logic [15:0] mr;
    logic [17:0] e;

    function automatic logic [15:0] mul_model(input logic [15:0] a, input logic [15:0] b);
        return a ^ {b[7:0], b[15:8]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input logic [15:0] base);
        for (int i = 0; i < 4; i++) begin
            bus.io_req_a[16*i +: 16] = base + 16'(i * 16'h0111);
            bus.io_req_b[16*i +: 16] = ~base ^ 16'(i << 4);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.io_req_valid = 4'h0;
        tick();
        reset = 1'b1;
        gnt_log.delete();
    endtask

    task automatic drain();
        bus.io_req_valid  = 4'h0;
        bus.io_resp_ready = 1'b1;
        for (int n = 0; n < 60 && (exp_q.size() != 0 || bus.io_resp_valid); n++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier stand-in: result of an issue appears MUL_LATENCY cycles later.
    always @(posedge clock) begin
        mv = bus.io_mul_in_valid;
        mr = mul_model(bus.io_mul_in_a, bus.io_mul_in_b);
        #1;
        for (int k = MUL_LATENCY - 1; k > 0; k--) mstage[k] = mstage[k-1];
        mstage[0] = mv ? mr : 16'hDEAD;
        bus.io_mul_out_result = mstage[MUL_LATENCY-1];
    end

    // Monitor: record grants into the scoreboard and compare every popped response.
    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.io_req_valid[i] && bus.io_req_ready[i]) begin
                    exp_q.push_back({2'(i), mul_model(bus.io_req_a[16*i +: 16], bus.io_req_b[16*i +: 16])});
                    gnt_log.push_back(i);
                    check("credit_bound", 32'(exp_q.size() <= FIFO_DEPTH), 32'd1);
                end
            end
            if (bus.io_req_ready != 4'h0) check("ready_onehot", 32'($countones(bus.io_req_ready)), 32'd1);
            if (dut.push_s) check("fifo_no_overflow", 32'((dut.fifo_count_r == 3'd4) && !dut.pop_s), 32'd0);
            if (bus.io_resp_valid) resp_seen++;
            if (bus.io_resp_valid && bus.io_resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL resp_unexpected: got id %0d data 0x%0h, expected no response", bus.io_resp_id, bus.io_resp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id", 32'(bus.io_resp_id), 32'(e[17:16]));
                    check("resp_data", 32'(bus.io_resp_data), 32'(e[15:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < MUL_LATENCY; k++) mstage[k] = 16'h0000;
        reset = 1'b0;
        bus.io_req_valid = 4'hF;
        bus.io_req_a = 64'h0;
        bus.io_req_b = 64'h0;
        bus.io_resp_ready = 1'b0;
        bus.io_mul_out_result = 16'h0000;
        @(negedge clock);
        check("rst_req_ready", 32'(bus.io_req_ready), 32'd0);
        check("rst_mul_valid", 32'(bus.io_mul_in_valid), 32'd0);
        check("rst_mul_a", 32'(bus.io_mul_in_a), 32'd0);
        check("rst_mul_b", 32'(bus.io_mul_in_b), 32'd0);
        check("rst_resp_valid", 32'(bus.io_resp_valid), 32'd0);
        check("rst_resp_id", 32'(bus.io_resp_id), 32'd0);
        check("rst_resp_data", 32'(bus.io_resp_data), 32'd0);

        // Single request from requester 2, first cycle after release.
        tick();
        reset = 1'b1;
        bus.io_req_valid = 4'b0100;
        bus.io_req_a = 64'h1111_3C00_2222_3333;
        bus.io_req_b = 64'h4444_4000_5555_6666;
        bus.io_resp_ready = 1'b1;
        @(negedge clock);
        check("single_ready_T", 32'(bus.io_req_ready), 32'h4);
        tick();
        bus.io_req_valid = 4'h0;
        bus.io_req_a = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        check("single_mul_valid_T1", 32'(bus.io_mul_in_valid), 32'd1);
        check("single_mul_a_T1", 32'(bus.io_mul_in_a), 32'h3C00);
        check("single_mul_b_T1", 32'(bus.io_mul_in_b), 32'h4000);
        tick();
        @(negedge clock);
        check("single_mul_valid_T2", 32'(bus.io_mul_in_valid), 32'd0);
        check("single_mul_a_hold", 32'(bus.io_mul_in_a), 32'h3C00);
        tick();
        tick();
        @(negedge clock);
        check("single_resp_early_T4", 32'(bus.io_resp_valid), 32'd0);
        tick();
        @(negedge clock);
        check("single_resp_valid_T5", 32'(bus.io_resp_valid), 32'd1);
        check("single_resp_id_T5", 32'(bus.io_resp_id), 32'd2);
        check("single_resp_data_T5", 32'(bus.io_resp_data), 32'h3C40);
        tick();
        drain();

        // Round-robin with all four requesting.
        do_reset();
        bus.io_resp_ready = 1'b1;
        set_ops(16'h1000);
        bus.io_req_valid = 4'hF;
        repeat (10) tick();
        bus.io_req_valid = 4'h0;
        check("rr4_count", 32'(gnt_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) check("rr4_grant", 32'(gnt_log[i]), 32'(i % 4));
        drain();

        // Round-robin with requesters 1 and 3 only.
        do_reset();
        set_ops(16'h2345);
        bus.io_req_valid = 4'b1010;
        repeat (8) tick();
        bus.io_req_valid = 4'h0;
        check("rr2_count", 32'(gnt_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) check("rr2_grant", 32'(gnt_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
        drain();

        // Backpressure: four credits, then one grant the cycle after the first pop.
        do_reset();
        bus.io_resp_ready = 1'b0;
        set_ops(16'h2200);
        bus.io_req_valid = 4'hF;
        repeat (10) tick();
        check("bp_grant_count", 32'(gnt_log.size()), 32'd4);
        @(negedge clock);
        check("bp_ready_stalled", 32'(bus.io_req_ready), 32'd0);
        tick();
        bus.io_resp_ready = 1'b1;
        @(negedge clock);
        check("bp_pop_cycle_resp_valid", 32'(bus.io_resp_valid), 32'd1);
        check("bp_no_grant_on_pop", 32'(bus.io_req_ready), 32'd0);
        tick();
        @(negedge clock);
        check("bp_grant_after_pop", 32'(bus.io_req_ready), 32'h1);
        tick();
        drain();

        // Three buffered plus one in flight, then push and pop together.
        do_reset();
        bus.io_resp_ready = 1'b0;
        set_ops(16'h5A5A);
        bus.io_req_valid = 4'hF;
        repeat (4) tick();
        bus.io_req_valid = 4'h0;
        repeat (3) tick();
        bus.io_resp_ready = 1'b1;
        @(negedge clock);
        check("full_resp_valid", 32'(bus.io_resp_valid), 32'd1);
        check("full_head_id", 32'(bus.io_resp_id), 32'd0);
        tick();
        set_ops(16'h6B6B);
        bus.io_req_valid = 4'hF;
        repeat (6) tick();
        drain();

        // Reset with two buffered and two in flight.
        do_reset();
        bus.io_resp_ready = 1'b0;
        set_ops(16'h0F0F);
        bus.io_req_valid = 4'hF;
        repeat (4) tick();
        bus.io_req_valid = 4'h0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        gnt_log.delete();
        @(negedge clock);
        check("midrst_resp_valid", 32'(bus.io_resp_valid), 32'd0);
        resp_seen = 0;
        repeat (5) tick();
        check("midrst_late_ignored", 32'(resp_seen), 32'd0);
        set_ops(16'h3131);
        bus.io_req_valid = 4'hF;
        @(negedge clock);
        check("midrst_ptr_zero", 32'(bus.io_req_ready), 32'h1);
        repeat (6) tick();
        check("midrst_credit_zero", 32'(gnt_log.size()), 32'd4);
        drain();

        // Pointer wrap from requester 3 to requester 0.
        do_reset();
        bus.io_resp_ready = 1'b1;
        set_ops(16'h7777);
        bus.io_req_valid = 4'b1000;
        @(negedge clock);
        check("wrap_grant3", 32'(bus.io_req_ready), 32'h8);
        tick();
        bus.io_req_valid = 4'b0001;
        @(negedge clock);
        check("wrap_grant0", 32'(bus.io_req_ready), 32'h1);
        tick();
        bus.io_req_valid = 4'b0011;
        @(negedge clock);
        check("wrap_ptr_one", 32'(bus.io_req_ready), 32'h2);
        tick();
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
